// File: rtl/multi_flex_counter_pkg.sv
// Shared types and constants for the multi-channel flexible counter.
package flex_counter_pkg;

  localparam int MODE_W = 2;

  // Per-channel counting behaviour selected on the mode input.
  typedef enum logic [MODE_W-1:0] {
    UP      = 2'd0,
    DOWN    = 2'd1,
    ONESHOT = 2'd2,
    HOLD    = 2'd3
  } mode_e;

endpackage

// File: rtl/multi_flex_counter_if.sv
// Control/status bundle for the multi-channel flexible counter.
interface multi_flex_counter_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) ();
  import flex_counter_pkg::*;

  logic [NUM_CH-1:0]              count_en;
  logic [NUM_CH-1:0]              clear;
  logic [NUM_CH-1:0][MODE_W-1:0]  mode;
  logic [NUM_CH-1:0][WIDTH-1:0]   rollover_val;
  logic [NUM_CH-1:0][WIDTH-1:0]   count;
  logic [NUM_CH-1:0]              rollover_flag;
  logic [NUM_CH-1:0]              done;
  logic                           any_rollover;

  // Controller side: drives enables/config, observes counts and flags.
  modport master (
    output count_en, clear, mode, rollover_val,
    input  count, rollover_flag, done, any_rollover
  );

  // Counter side.
  modport slave (
    input  count_en, clear, mode, rollover_val,
    output count, rollover_flag, done, any_rollover
  );
endinterface

// File: rtl/multi_flex_counter_chan.sv
// One counter channel: UP/DOWN wrap counting, ONESHOT with sticky done, HOLD.
module flex_counter_chan
  import flex_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] rv_i,
  output logic [WIDTH-1:0] count_o,
  output logic             flag_o,
  output logic             done_o,
  output logic             flag_next_o
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;
  logic             done_q, done_d;

  // Next-state: clear beats enable; the >= compare in UP wraps before all-ones can overflow.
  always_comb begin
    count_d = count_q;
    flag_d  = 1'b0;
    done_d  = done_q;
    if (clear_i) begin
      count_d = ZERO;
      done_d  = 1'b0;
    end else if (en_i) begin
      case (mode_i)
        UP: begin
          if (count_q >= rv_i) begin
            count_d = ZERO;
            flag_d  = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
        DOWN: begin
          if (count_q == ZERO) begin
            count_d = rv_i;
            flag_d  = 1'b1;
          end else begin
            count_d = count_q - ONE;
          end
        end
        ONESHOT: begin
          if (count_q < rv_i) begin
            count_d = count_q + ONE;
            if ((count_q + ONE) == rv_i) begin
              done_d = 1'b1;
            end else begin
              done_d = done_q;
            end
          end else begin
            count_d = count_q;
            done_d  = 1'b1;
          end
        end
        HOLD:    count_d = count_q;
        default: count_d = count_q;
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= ZERO;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign count_o     = count_q;
  assign flag_o      = flag_q;
  assign done_o      = done_q;
  assign flag_next_o = flag_d;

endmodule

// File: rtl/multi_flex_counter.sv
// NUM_CH independent flexible counters plus a registered any-rollover summary.
module multi_flex_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  multi_flex_counter_if.slave  bus
);

  logic [NUM_CH-1:0] flag_next_s;
  logic              any_rollover_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    flex_counter_chan #(.WIDTH(WIDTH)) u_chan (
      .clk_i       (CLK),
      .rst_i       (RST),
      .clear_i     (bus.clear[g]),
      .en_i        (bus.count_en[g]),
      .mode_i      (mode_e'(bus.mode[g])),
      .rv_i        (bus.rollover_val[g]),
      .count_o     (bus.count[g]),
      .flag_o      (bus.rollover_flag[g]),
      .done_o      (bus.done[g]),
      .flag_next_o (flag_next_s[g])
    );
  end

  // Summary pulse built from next-state flags so it lines up with the per-channel flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      any_rollover_q <= 1'b0;
    end else begin
      any_rollover_q <= |flag_next_s;
    end
  end

  assign bus.any_rollover = any_rollover_q;

endmodule

// File: tb/tb_multi_flex_counter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_multi_flex_counter;

  localparam int NCH = 4;
  localparam int W   = 4;

  logic CLK;
  logic RST;
  logic [NCH-1:0]        en;
  logic [NCH-1:0]        clr;
  logic [NCH-1:0][1:0]   md;
  logic [NCH-1:0][W-1:0] rv;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt  [NCH];
  int m_flag [NCH];
  int m_done [NCH];
  int m_any;

  multi_flex_counter_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

  assign bus.count_en     = en;
  assign bus.clear        = clr;
  assign bus.mode         = md;
  assign bus.rollover_val = rv;

  multi_flex_counter #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: apply the per-edge rules with plain integer arithmetic.
  task automatic model_edge();
    int c, r, any;
    any = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      c = m_cnt[ch];
      r = int'(rv[ch]);
      m_flag[ch] = 0;
      if (RST) begin
        m_cnt[ch] = 0; m_done[ch] = 0;
      end else if (clr[ch]) begin
        m_cnt[ch] = 0; m_done[ch] = 0;
      end else if (en[ch]) begin
        case (int'(md[ch]))
          0: if (c >= r) begin m_cnt[ch] = 0; m_flag[ch] = 1; end
             else m_cnt[ch] = c + 1;
          1: if (c == 0) begin m_cnt[ch] = r; m_flag[ch] = 1; end
             else m_cnt[ch] = c - 1;
          2: if (c < r) begin
               m_cnt[ch] = c + 1;
               if (c + 1 == r) m_done[ch] = 1;
             end else m_done[ch] = 1;
          default: ;
        endcase
      end
      if (m_flag[ch] != 0) any = 1;
    end
    m_any = RST ? 0 : any;
  endtask

  task automatic check_all();
    for (int ch = 0; ch < NCH; ch++) begin
      check_eq($sformatf("model_count[%0d]", ch), int'(bus.count[ch]), m_cnt[ch]);
      check_eq($sformatf("model_flag[%0d]", ch), int'(bus.rollover_flag[ch]), m_flag[ch]);
      check_eq($sformatf("model_done[%0d]", ch), int'(bus.done[ch]), m_done[ch]);
    end
    check_eq("model_any", int'(bus.any_rollover), m_any);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b1; en = '0; clr = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [W-1:0] r, input logic e);
    md[ch] = m; rv[ch] = r; en[ch] = e;
  endtask

  int up_c [5] = '{1, 2, 3, 0, 1};
  int up_f [5] = '{0, 0, 0, 1, 0};
  int dn_c [4] = '{2, 1, 0, 2};
  int dn_f [4] = '{1, 0, 0, 1};

  initial begin
    RST = 1'b1; en = '0; clr = '0; md = '0; rv = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_cnt[ch] = 0; m_flag[ch] = 0; m_done[ch] = 0;
    end
    m_any = 0;
    tick();
    tick();
    check_eq("reset_count", int'(bus.count), 0);
    check_eq("reset_flags", int'(bus.rollover_flag), 0);
    check_eq("reset_done", int'(bus.done), 0);
    check_eq("reset_any", int'(bus.any_rollover), 0);
    RST = 1'b0;

    // UP, rollover 3
    set_ch(0, 2'd0, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("up_count", int'(bus.count[0]), up_c[i]);
      check_eq("up_flag", int'(bus.rollover_flag[0]), up_f[i]);
      check_eq("up_any", int'(bus.any_rollover), up_f[i]);
    end

    // DOWN, rollover 2, from reset
    do_reset();
    set_ch(0, 2'd1, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("down_count", int'(bus.count[0]), dn_c[i]);
      check_eq("down_flag", int'(bus.rollover_flag[0]), dn_f[i]);
    end

    // ONESHOT, rollover 5
    do_reset();
    set_ch(0, 2'd2, 4'd5, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq("oneshot_count", int'(bus.count[0]), i);
      check_eq("oneshot_done", int'(bus.done[0]), (i == 5) ? 1 : 0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("oneshot_hold", int'(bus.count[0]), 5);
      check_eq("oneshot_sticky", int'(bus.done[0]), 1);
      check_eq("oneshot_noflag", int'(bus.rollover_flag[0]), 0);
    end
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    check_eq("oneshot_clr_count", int'(bus.count[0]), 0);
    check_eq("oneshot_clr_done", int'(bus.done[0]), 0);

    // Priority
    set_ch(0, 2'd0, 4'd15, 1'b1);
    repeat (7) tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    check_eq("clr_beats_en", int'(bus.count[0]), 0);
    repeat (7) tick();
    check_eq("count_7", int'(bus.count[0]), 7);
    RST = 1'b1; clr = '1;
    tick();
    RST = 1'b0; clr = '0;
    check_eq("rst_beats_clr_count", int'(bus.count), 0);
    check_eq("rst_beats_clr_done", int'(bus.done), 0);
    check_eq("rst_beats_clr_any", int'(bus.any_rollover), 0);
    repeat (3) tick();
    en[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("frozen", int'(bus.count[0]), 3);
    end

    // Boundaries
    do_reset();
    set_ch(0, 2'd0, 4'd15, 1'b1);
    repeat (15) tick();
    check_eq("all_ones", int'(bus.count[0]), 15);
    tick();
    check_eq("wrap15_count", int'(bus.count[0]), 0);
    check_eq("wrap15_flag", int'(bus.rollover_flag[0]), 1);
    rv[0] = 4'd10;
    repeat (8) tick();
    check_eq("count_8", int'(bus.count[0]), 8);
    rv[0] = 4'd4;
    tick();
    check_eq("lowered_rv_count", int'(bus.count[0]), 0);
    check_eq("lowered_rv_flag", int'(bus.rollover_flag[0]), 1);
    rv[0] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rv0_up_count", int'(bus.count[0]), 0);
      check_eq("rv0_up_flag", int'(bus.rollover_flag[0]), 1);
    end
    md[0] = 2'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rv0_down_count", int'(bus.count[0]), 0);
      check_eq("rv0_down_flag", int'(bus.rollover_flag[0]), 1);
    end

    // Independence: ch1 UP rv2 and ch3 DOWN rv1 wrap together on the third edge
    do_reset();
    set_ch(0, 2'd2, 4'd9, 1'b1);
    set_ch(1, 2'd0, 4'd2, 1'b1);
    set_ch(2, 2'd3, 4'd6, 1'b1);
    set_ch(3, 2'd1, 4'd1, 1'b1);
    repeat (3) tick();
    check_eq("indep_flags", int'(bus.rollover_flag), 10);
    check_eq("indep_any", int'(bus.any_rollover), 1);
    check_eq("indep_ch0", int'(bus.count[0]), 3);
    check_eq("indep_ch2", int'(bus.count[2]), 0);
    tick();
    check_eq("indep_any_once", int'(bus.any_rollover), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      en  = NCH'($urandom);
      clr = ($urandom_range(0, 11) == 0) ? NCH'($urandom) : '0;
      RST = ($urandom_range(0, 59) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 9) == 0) md[ch] = 2'($urandom);
        if ($urandom_range(0, 14) == 0) rv[ch] = W'($urandom);
      end
      tick();
    end
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
